// File: rtl/miner_sequencer.sv
// Sequences a bank of SHA hashing cores over a nonce range for one mining job and
// returns in-range golden nonces one at a time through a valid/ready handshake.

module miner_sequencer_lane #(
    parameter int IDX = 0
) (
    input  logic [31:0] base,
    input  logic [31:0] end_nonce,
    input  logic        found,
    output logic        hit
);
    logic [32:0] nonce;

    // 33-bit so a lane hashing past 0xFFFFFFFF never looks in range
    assign nonce = {1'b0, base} + 33'(IDX);
    assign hit   = found & (nonce <= {1'b0, end_nonce});
endmodule

module miner_sequencer #(
    parameter int NUM_CORES = 4,
    parameter int CHECK_LAT = 2
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    job_valid,
    output logic                    job_ready,
    input  logic [31:0]             job_start_nonce,
    input  logic [31:0]             job_end_nonce,
    input  logic                    abort,
    output logic                    load_state,
    output logic [5:0]              cycle,
    output logic [31:0]             base_nonce,
    input  logic [NUM_CORES-1:0]    core_found,
    input  logic [32*NUM_CORES-1:0] core_nonce,
    output logic                    result_valid,
    output logic [31:0]             result_nonce,
    input  logic                    result_ready,
    output logic                    busy,
    output logic                    done
);
    localparam int CW = (CHECK_LAT > 1) ? $clog2(CHECK_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN, S_CHECK, S_REPORT, S_ADVANCE, S_DONE
    } state_t;

    state_t                         state, state_nx;
    logic [5:0]                     cnt;
    logic [CW-1:0]                  chk_cnt;
    logic [31:0]                    end_r;
    logic [NUM_CORES-1:0]           pending, hit, low, pending_clr;
    logic [NUM_CORES-1:0][31:0]     nonce_r;
    logic [32:0]                    adv;
    logic                           chk_last;

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_lane
        miner_sequencer_lane #(.IDX(i)) u_lane (
            .base      (base_nonce),
            .end_nonce (end_r),
            .found     (core_found[i]),
            .hit       (hit[i])
        );
    end

    assign low         = pending & (~pending + NUM_CORES'(1));
    assign pending_clr = pending & ~low;
    assign adv         = {1'b0, base_nonce} + 33'(NUM_CORES);
    assign chk_last    = (chk_cnt == CW'(CHECK_LAT - 1));

    always_comb begin
        result_nonce = '0;
        for (int i = 0; i < NUM_CORES; i++)
            if (low[i]) result_nonce = result_nonce | nonce_r[i];
    end

    assign job_ready    = (state == S_IDLE);
    assign load_state   = (state == S_IDLE) || (state == S_LOAD) || (state == S_DONE);
    assign cycle        = load_state ? 6'd0 : cnt;
    assign result_valid = (state == S_REPORT);
    assign busy         = (state != S_IDLE);
    assign done         = (state == S_DONE);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (job_valid)
                           state_nx = (job_start_nonce > job_end_nonce) ? S_DONE : S_LOAD;
            S_LOAD:    state_nx = S_RUN;
            S_RUN:     if (cnt == 6'd63) state_nx = S_CHECK;
            S_CHECK:   if (chk_last) state_nx = (|hit) ? S_REPORT : S_ADVANCE;
            S_REPORT:  if (result_ready && pending_clr == '0) state_nx = S_ADVANCE;
            S_ADVANCE: state_nx = (adv[32] || adv > {1'b0, end_r}) ? S_DONE : S_LOAD;
            S_DONE:    state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
        if (abort && state != S_IDLE) state_nx = S_DONE;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            chk_cnt    <= '0;
            base_nonce <= '0;
            end_r      <= '0;
            pending    <= '0;
            nonce_r    <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: if (job_valid) begin
                    base_nonce <= job_start_nonce;
                    end_r      <= job_end_nonce;
                end
                S_LOAD: begin
                    cnt     <= '0;
                    chk_cnt <= '0;
                end
                S_RUN:   if (cnt != 6'd63) cnt <= cnt + 6'd1;
                S_CHECK: begin
                    chk_cnt <= chk_cnt + CW'(1);
                    if (chk_last) begin
                        pending <= hit;
                        for (int i = 0; i < NUM_CORES; i++)
                            nonce_r[i] <= core_nonce[32*i +: 32];
                    end
                end
                S_REPORT:  if (result_ready) pending <= pending_clr;
                S_ADVANCE: if (state_nx == S_LOAD) base_nonce <= adv[31:0];
                default: ;
            endcase
            // abort wins over any handshake bookkeeping above
            if (abort && state != S_IDLE) pending <= '0;
        end
    end
endmodule

// File: tb/tb_miner_sequencer.sv
// Randomized scoreboard bench for miner_sequencer: a reference model lists the golden
// nonces and pass bases of each job; a monitor pops and compares them as the DUT emits.

module tb_miner_sequencer;
    localparam int NC = 4;
    localparam int CL = 2;

    logic                clk = 1'b0;
    logic                n_rst;
    logic                job_valid, job_ready, abort, load_state;
    logic [31:0]         job_start_nonce, job_end_nonce, base_nonce, result_nonce;
    logic [5:0]          cycle;
    logic [NC-1:0]       core_found;
    logic [32*NC-1:0]    core_nonce;
    logic                result_valid, result_ready, busy, done;

    int checks = 0, failures = 0;
    int cyc = 0, acc = 0, done_cnt = 0, exp_done = 0;
    int gmode = 0, rdy_mode = 0, lo_left = 0;
    logic [31:0] seed = '0;
    logic [31:0] gq[$];
    logic [31:0] exp_res[$];
    logic [31:0] exp_base[$];

    miner_sequencer #(.NUM_CORES(NC), .CHECK_LAT(CL)) dut (
        .clk(clk), .n_rst(n_rst), .job_valid(job_valid), .job_ready(job_ready),
        .job_start_nonce(job_start_nonce), .job_end_nonce(job_end_nonce), .abort(abort),
        .load_state(load_state), .cycle(cycle), .base_nonce(base_nonce),
        .core_found(core_found), .core_nonce(core_nonce), .result_valid(result_valid),
        .result_nonce(result_nonce), .result_ready(result_ready), .busy(busy), .done(done)
    );

    initial forever begin
        #5 clk = 1'b1; cyc++;
        #5 clk = 1'b0;
    end

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit golden(input logic [31:0] n);
        logic [31:0] h;
        if (gmode == 1) begin
            foreach (gq[k]) if (gq[k] == n) return 1'b1;
            return 1'b0;
        end
        if (gmode == 2) begin
            h = (n * 32'h9E3779B1) ^ seed;
            return h[31:29] == 3'd0;
        end
        return 1'b0;
    endfunction

    // Core bank model: core i hashes base+i and raises found once its rounds end
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < NC; i++) begin
            core_nonce[32*i +: 32] = base_nonce + 32'(i);
            core_found[i] = (cycle == 6'd63) && !load_state && golden(base_nonce + 32'(i));
        end
    end

    // Consumer ready: 0 always high, 1 random, 2 low for lo_left presented cycles then high
    initial forever begin
        @(posedge clk); #1;
        case (rdy_mode)
            1:       result_ready = ($urandom_range(0, 2) != 0);
            2: begin
                result_ready = (lo_left == 0);
                if (result_valid && lo_left > 0) lo_left--;
            end
            default: result_ready = 1'b1;
        endcase
    end

    // Monitor
    initial begin
        bit          prev_hold;
        logic [31:0] prev_nonce;
        prev_hold = 1'b0;
        prev_nonce = '0;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                prev_hold = 1'b0;
                continue;
            end
            if (prev_hold) begin
                chk("hold_valid", result_valid, 1);
                chk("hold_nonce", result_nonce, prev_nonce);
            end
            if (result_valid && result_ready) begin
                if (exp_res.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_result: got %0h expected none", result_nonce);
                end else chk("result_nonce", result_nonce, exp_res.pop_front());
            end
            prev_hold  = result_valid && !result_ready;
            prev_nonce = result_nonce;
            if (busy && load_state && !done) begin
                if (exp_base.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_pass: got base %0h expected none", base_nonce);
                end else chk("pass_base", base_nonce, exp_base.pop_front());
            end
            if (done) begin
                done_cnt++;
                chk("results_left_at_done", exp_res.size(), 0);
                chk("passes_left_at_done", exp_base.size(), 0);
            end
        end
    end

    task automatic send_job(input logic [31:0] s, input logic [31:0] e, input int extra);
        int t = 0;
        while (!job_ready && t < 2000) begin
            @(posedge clk); #1; t++;
        end
        chk("job_ready_wait", job_ready, 1);
        if (s <= e) begin
            for (longint unsigned n = s; n <= e; n++)
                if (golden(32'(n))) exp_res.push_back(32'(n));
            for (longint unsigned b = s; b <= e; b += NC)
                exp_base.push_back(32'(b));
        end
        exp_done++;
        job_valid = 1'b1; job_start_nonce = s; job_end_nonce = e;
        @(posedge clk); #1;
        acc = cyc;
        // keep presenting junk jobs while busy; none may be taken
        for (int k = 0; k < extra && s <= e; k++) begin
            job_start_nonce = $urandom; job_end_nonce = $urandom;
            @(posedge clk); #1;
        end
        job_valid = 1'b0;
        @(negedge clk);
        chk("job_ready_busy", job_ready, 0);
    endtask

    task automatic wait_done(output int lat);
        int t = 0;
        lat = -1;
        while (t < 20000) begin
            if (done) break;
            @(negedge clk); t++;
        end
        chk("done_seen", done, 1);
        if (done) lat = cyc - acc;
        @(posedge clk); #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_job_ready"}, job_ready, 1);
        chk({tag, "_load_state"}, load_state, 1);
        chk({tag, "_cycle"}, cycle, 0);
        chk({tag, "_base_nonce"}, base_nonce, 0);
        chk({tag, "_result_valid"}, result_valid, 0);
        chk({tag, "_result_nonce"}, result_nonce, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic wait_until_cycle(input logic [5:0] c);
        int t = 0;
        while (!(busy && !load_state && cycle == c) && t < 2000) begin
            @(posedge clk); #1; t++;
        end
        chk("reach_cycle", cycle, c);
    endtask

    initial begin
        int lat, dsnap;
        logic [31:0] s, e;
        n_rst = 1'b0; job_valid = 1'b0; abort = 1'b0; result_ready = 1'b1;
        job_start_nonce = '0; job_end_nonce = '0; core_found = '0; core_nonce = '0;
        #23;
        check_reset_vals("reset");
        n_rst = 1'b1;
        @(posedge clk); #1;

        // single pass, no hit: exact latency
        gmode = 0; rdy_mode = 0;
        send_job(32'h100, 32'h103, 0);
        wait_done(lat);
        chk("nohit_latency", lat, 68);

        // abort ignored in IDLE
        abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_busy", busy, 0);
        chk("idle_abort_done", done, 0);

        // multi-hit ordering with held ready
        gmode = 1; gq = '{32'd1, 32'd3}; rdy_mode = 2; lo_left = 5;
        send_job(32'h0, 32'hFF, 2);
        wait_done(lat);

        // range masking
        gq = '{32'h12, 32'h13}; rdy_mode = 0;
        send_job(32'h10, 32'h11, 1);
        wait_done(lat);

        // top of nonce space; lane hashing 0 after wrap must be masked
        gq = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h0};
        send_job(32'hFFFFFFFC, 32'hFFFFFFFF, 0);
        wait_done(lat);

        // abort in RUN at cycle 30
        gmode = 0;
        send_job(32'h100, 32'h1FF, 0);
        wait_until_cycle(6'd30);
        abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
        exp_res.delete(); exp_base.delete();
        @(negedge clk);
        chk("abort_run_done", done, 1);
        @(negedge clk);
        chk("abort_run_idle_ready", job_ready, 1);
        chk("abort_run_idle_load", load_state, 1);

        // abort coinciding with a REPORT handshake
        gmode = 1; gq = '{32'h20, 32'h21, 32'h22};
        send_job(32'h20, 32'h40, 0);
        begin
            int t = 0;
            while (!result_valid && t < 2000) begin
                @(posedge clk); #1; t++;
            end
            chk("report_reached", result_valid, 1);
        end
        abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
        chk("abort_report_taken", exp_res.size(), 2);
        exp_res.delete(); exp_base.delete();
        @(negedge clk);
        chk("abort_report_valid", result_valid, 0);
        chk("abort_report_done", done, 1);
        @(posedge clk); #1;

        // reset during CHECK
        gmode = 0;
        send_job(32'h500, 32'h5FF, 0);
        wait_until_cycle(6'd63);
        @(posedge clk); #2;
        dsnap = done_cnt;
        exp_done--;
        n_rst = 1'b0; #1;
        check_reset_vals("midreset");
        exp_res.delete(); exp_base.delete();
        #20;
        n_rst = 1'b1;
        @(posedge clk); #1;
        chk("midreset_no_done", done_cnt, dsnap);
        send_job(32'h7, 32'h9, 0);
        wait_done(lat);

        // randomized jobs
        gmode = 2; rdy_mode = 1;
        for (int j = 0; j < 14; j++) begin
            int len, kind;
            seed = $urandom;
            len  = $urandom_range(0, 22);
            kind = $urandom_range(0, 3);
            case (kind)
                0: s = $urandom_range(0, 1000);
                1: s = $urandom;
                2: s = 32'hFFFFFFFF - $urandom_range(0, 25);
                default: s = $urandom_range(1, 32'h7FFFFFFF);
            endcase
            if (kind == 3) e = s - $urandom_range(1, s < 20 ? s : 20);
            else e = (longint'(s) + len > 64'hFFFFFFFF) ? 32'hFFFFFFFF : s + len;
            send_job(s, e, $urandom_range(0, 2));
            wait_done(lat);
        end

        chk("done_count", done_cnt, exp_done);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/miner_sequencer.md
# miner_sequencer

Sequences a bank of `NUM_CORES` SHA hashing cores over a nonce range for a single mining job. It drives the cores' shared `loadState`, round counter and base nonce. It samples each core's found flag and nonce at the end of every pass, and returns winning nonces to the host-side interface one at a time through a valid/ready handshake. Core *i* is wired externally with `nonceFactor = i`, so the nonce it hashes is `base_nonce + i`.

## Interface
Parameters:
- `NUM_CORES`, default 4: number of hashing cores; legal range 1–16.
- `CHECK_LAT`, default 2: cycles after round 63 before core flags are valid; must be ≥ 1.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `job_valid`  in  1  a new job is presented.
- `job_ready`  out  1  the sequencer can accept a job; high only in IDLE.
- `job_start_nonce`  in  32  first nonce of the range, inclusive.
- `job_end_nonce`  in  32  last nonce of the range, inclusive.
- `abort`  in  1  abandon the current job.
- `load_state`  out  1  high: cores reload midstate and their checkers are held cleared.
- `cycle`  out  6  SHA round index driven to all cores.
- `base_nonce`  out  32  nonce driven to all cores.
- `core_found`  in  NUM_CORES  bit *i* is the found flag of core *i* (`coreOutput[32]`).
- `core_nonce`  in  32*NUM_CORES  slice *i* is core *i*'s nonce (`coreOutput[31:0]`).
- `result_valid`  out  1  a golden nonce is available.
- `result_nonce`  out  32  the golden nonce.
- `result_ready`  in  1  the consumer accepts the result.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when a job finishes, whether exhausted or aborted.

## Operation
- **IDLE**
  - `job_ready = 1`, `load_state = 1`, `cycle = 0`.
  - On `job_valid`: latch start and end into `base_nonce` and an end register, then go to LOAD.
  - If start > end, go straight to DONE.
- **LOAD** (1 cycle): `load_state = 1`, `cycle = 0`; then go to RUN.
- **RUN** (64 cycles): `load_state = 0`; a 6-bit counter drives `cycle` 0→63; after 63, go to CHECK.
- **CHECK** (`CHECK_LAT` cycles): `cycle` holds 63.
  - On the last CHECK cycle, latch `pending = core_found & in_range` and latch all `core_nonce` slices.
  - `in_range[i] = (base_nonce + i ≤ end)`, computed in 33 bits.
  - If `pending ≠ 0`, go to REPORT; otherwise go to ADVANCE.
- **REPORT**
  - `result_valid = 1`; `result_nonce` = latched nonce of the lowest set bit of `pending`.
  - On `result_valid & result_ready`: clear that bit. If `pending` becomes 0, go to ADVANCE; otherwise present the next bit on the following cycle.
  - `result_valid`/`result_nonce` hold stable while `result_ready` is low.
- **ADVANCE** (1 cycle): compute `next = base_nonce + NUM_CORES` in 33 bits.
  - If `next > end`, or bit 32 is set (wrap), go to DONE.
  - Otherwise set `base_nonce = next[31:0]` and go to LOAD.
- **DONE** (1 cycle): `done = 1`, then go to IDLE. `base_nonce` keeps its last value.
- **abort**
  - Any non-IDLE state goes to DONE on the next edge; `pending` is cleared and `result_valid` drops.
  - If abort coincides with a REPORT handshake, the transfer counts as completed.
  - In IDLE, abort is ignored.
- A `job_valid` arriving while busy is not accepted; `job_ready = 0`.

## Timing
- Reset values:
  - state IDLE, `job_ready = 1`, `load_state = 1`, `cycle = 0`, `base_nonce = 0`.
  - `result_valid = 0`, `result_nonce = 0`, `busy = 0`, `done = 0`, `pending = 0`.
- All outputs are registered or decoded from registered state; no combinational path exists from inputs to outputs.
- Job accept: the `job_valid` edge in IDLE puts LOAD in the next cycle.
- Pass with no winners: LOAD(1) + RUN(64) + CHECK(`CHECK_LAT`) + ADVANCE(1) = 68 cycles at default parameters.
- Each reported result adds ≥ 1 cycle; a back-to-back `result_ready` gives one result per cycle.
- `done` asserts exactly one cycle, in the cycle after the final ADVANCE or after the abort edge.
- `n_rst` asserted mid-job resets all state immediately (asynchronous); the in-flight job is lost and no `done` is issued.

## Test plan
- **Single pass, no hit:** start=0x100, end=0x103, NUM_CORES=4, no `core_found` → exactly one LOAD/RUN/CHECK; `done` at cycle 68 after accept; `result_valid` never high.
- **Multi-hit ordering:** start=0, end=0xFF; in pass 0, `core_found = 4'b1010` with nonces 1 and 3; `result_ready` low for 5 cycles, then high → result 1 held stable for those cycles, then 3 on the next cycle, then ADVANCE with `base_nonce = 4`.
- **Range masking:** start=0x10, end=0x11; cores 2 and 3 flag found → no result (out of range); one pass only, then `done`.
- **Wrap-around:** start=0xFFFFFFFC, end=0xFFFFFFFF → one pass covering 0xFFFFFFFC..0xFFFFFFFF, then DONE; `base_nonce` never wraps to 0.
- **Abort:** abort in RUN at cycle 30 → `done` next cycle, IDLE after that, `load_state = 1`; abort during REPORT with `result_ready = 1` → one transfer counted, `result_valid` low after.
- **Reset mid-job:** `n_rst` low during CHECK → outputs take reset values immediately, with no `done` pulse; a new job is accepted afterwards.
